// File: rtl/pc_pkg.sv
// Shared types and constants for the IF-stage program-counter generator.
// Optional trap/return redirects are enabled by defining PC_TRAP_EN.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_JMP  = 3'd1,
    CAUSE_BR   = 3'd2,
    CAUSE_MRET = 3'd3,
    CAUSE_TRAP = 3'd4
  } redir_cause_e;

  localparam int unsigned PC_DEFAULT_INC = 4;

  // A fetch target is word-aligned only when its two low bits are zero.
  function automatic logic misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational redirect priority select: trap > mret > br > jmp (trap/mret
// only with PC_TRAP_EN). Target is word-aligned; misalign flags dropped bits.
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
`ifdef PC_TRAP_EN
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
`endif
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [XLEN-1:0] jmp_target_i,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_target_o,
  output logic            redir_misalign_o,
  output redir_cause_e    redir_cause_o
);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    raw_target    = '0;
    redir_cause_o = CAUSE_NONE;
`ifdef PC_TRAP_EN
    if (trap_i) begin
      raw_target    = trap_vec_i;
      redir_cause_o = CAUSE_TRAP;
    end else if (mret_i) begin
      raw_target    = mepc_i;
      redir_cause_o = CAUSE_MRET;
    end else
`endif
    if (br_taken_i) begin
      raw_target    = br_target_i;
      redir_cause_o = CAUSE_BR;
    end else if (jmp_i) begin
      raw_target    = jmp_target_i;
      redir_cause_o = CAUSE_JMP;
    end
  end

  assign redir_valid_o    = (redir_cause_o != CAUSE_NONE);
  assign redir_target_o   = {raw_target[XLEN-1:2], 2'b00};
  assign redir_misalign_o = redir_valid_o & misaligned(raw_target[1:0]);

endmodule

// File: rtl/pc_gen.sv
// IF-stage program-counter generator: boot delay, fetch handshake, stall hold,
// prioritised redirects with a pending buffer. PC_TRAP_EN adds trap/mret ports.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int unsigned     INC        = PC_DEFAULT_INC,
  parameter int unsigned     BOOT_DELAY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            if_ready_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            jmp_i,
  input  logic [XLEN-1:0] jmp_target_i,
`ifdef PC_TRAP_EN
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
`endif
  output logic            if_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            flush_o,
  output logic            misalign_o,
  output pc_state_e       dbg_state_o,
  output redir_cause_e    dbg_cause_o
);

  localparam int unsigned CNT_W = (BOOT_DELAY < 2) ? 1 : $clog2(BOOT_DELAY + 1);

  // Handshake: a fetch is accepted (fire) on a cycle where if_valid_o and
  // if_ready_i are both high and the hazard unit is not stalling; while
  // if_valid_o is high and no fire occurs, pc_o is held unchanged.
  pc_state_e       state;
  logic [CNT_W-1:0] boot_cnt;
  logic            boot_done;
  logic            fire;
  logic [XLEN-1:0] pend_target;
  logic            pend_misalign;

  logic            redir_valid;
  logic [XLEN-1:0] redir_target;
  logic            redir_misalign;
  redir_cause_e    redir_cause;

  pc_redirect_arb #(
    .XLEN (XLEN)
  ) u_arb (
`ifdef PC_TRAP_EN
    .trap_i           (trap_i),
    .trap_vec_i       (trap_vec_i),
    .mret_i           (mret_i),
    .mepc_i           (mepc_i),
`endif
    .br_taken_i       (br_taken_i),
    .br_target_i      (br_target_i),
    .jmp_i            (jmp_i),
    .jmp_target_i     (jmp_target_i),
    .redir_valid_o    (redir_valid),
    .redir_target_o   (redir_target),
    .redir_misalign_o (redir_misalign),
    .redir_cause_o    (redir_cause)
  );

  assign fire      = if_valid_o & if_ready_i & ~stall_i;
  assign pc_plus_o = pc_o + XLEN'(INC);
  // BOOT is always occupied for at least the first cycle after reset, so a
  // delay of 0 or 1 both leave BOOT on the first post-reset edge.
  assign boot_done = ((32'(boot_cnt) + 32'd1) >= BOOT_DELAY);

  assign dbg_state_o = state;
  assign dbg_cause_o = redir_cause;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_BOOT;
      boot_cnt      <= '0;
      pc_o          <= RESET_VEC;
      pend_target   <= '0;
      pend_misalign <= 1'b0;
      if_valid_o    <= 1'b0;
      flush_o       <= 1'b0;
      misalign_o    <= 1'b0;
    end else begin
      flush_o    <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        ST_BOOT: begin
          boot_cnt <= boot_cnt + 1'b1;
          if (boot_done) begin
            state      <= ST_RUN;
            if_valid_o <= 1'b1;
          end
        end
        ST_RUN: begin
          if (redir_valid) begin
            if (fire) begin
              pc_o       <= redir_target;
              flush_o    <= 1'b1;
              misalign_o <= redir_misalign;
            end else begin
              pend_target   <= redir_target;
              pend_misalign <= redir_misalign;
              state         <= ST_PEND;
            end
          end else if (fire) begin
            pc_o <= pc_o + XLEN'(INC);
          end
        end
        ST_PEND: begin
          if (fire) begin
            // A redirect arriving on the fire cycle is newer than the buffer.
            pc_o       <= redir_valid ? redir_target : pend_target;
            misalign_o <= redir_valid ? redir_misalign : pend_misalign;
            flush_o    <= 1'b1;
            state      <= ST_RUN;
          end else if (redir_valid) begin
            pend_target   <= redir_target;
            pend_misalign <= redir_misalign;
          end
        end
        default: begin
          state      <= ST_BOOT;
          boot_cnt   <= '0;
          if_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
